// File: rtl/sw_btn_reader_pkg.sv
// Shared constants and helpers for the switch/button reader block.
// Register indices, base address and a small popcount helper.
package sw_btn_reader_pkg;

  localparam logic [31:0] SW_BTN_BASE = 32'h1000_0000;

  localparam logic [1:0] REG_SW    = 2'd0;
  localparam logic [1:0] REG_BTN   = 2'd1;
  localparam logic [1:0] REG_PRESS = 2'd2;
  localparam logic [1:0] REG_CNT   = 2'd3;

  localparam int NUM_SW  = 16;
  localparam int NUM_BTN = 5;
  localparam int NUM_IN  = NUM_SW + NUM_BTN;

  function automatic logic [2:0] count_ones5(
    input logic [4:0] v
  );
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 5; i++)
      n = n + {2'b0, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/sw_btn_reader_if.sv
// CPU read-bus bundle for the switch/button reader.
// master: cs/rd/addr out, rdata in; slave: the reverse.
interface sw_btn_reader_if;
  logic        cs;
  logic        rd;
  logic [1:0]  addr;
  logic [31:0] rdata;

  modport master (
    output cs, rd, addr,
    input  rdata
  );

  modport slave (
    input  cs, rd, addr,
    output rdata
  );
endinterface

// File: rtl/sw_btn_reader_debounce_bit.sv
// One input bit: 2-flop synchronizer, sample history, accept logic.
// Ports: clk, reset, sample (shared pulse), din (raw), dout (debounced).
module debounce_bit #(
  parameter int DEB_SAMPLES = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic sample,
  input  logic din,
  output logic dout
);

  logic                   s1;
  logic                   s2;
  logic [DEB_SAMPLES-1:0] hist;
  logic [DEB_SAMPLES-1:0] hist_nx;

  generate
    if (DEB_SAMPLES > 1) begin : g_deep
      assign hist_nx = {hist[DEB_SAMPLES-2:0], s2};
    end else begin : g_one
      assign hist_nx = s2;
    end
  endgenerate

  // Acceptance looks at the history including the value
  // shifted in on this pulse, so the last agreeing sample
  // updates dout on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      hist <= '0;
      dout <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (sample) begin
        hist <= hist_nx;
        if (&hist_nx)
          dout <= 1'b1;
        else if (~|hist_nx)
          dout <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sw_btn_reader.sv
// Debounced switch/button reader with sticky press flags and counter.
// Ports: clk, reset, bus (cs/rd/addr/rdata slave), sw[15:0], btn[4:0].
module sw_btn_reader
  import sw_btn_reader_pkg::*;
#(
  parameter int DEB_TICK    = 100000,
  parameter int DEB_SAMPLES = 3
) (
  input  logic              clk,
  input  logic              reset,
  sw_btn_reader_if.slave    bus,
  input  logic [15:0]       sw,
  input  logic [4:0]        btn
);

  localparam int TW =
    (DEB_TICK > 1) ? $clog2(DEB_TICK) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(DEB_TICK - 1);

  logic [TW-1:0]     tick;
  logic              sample;
  logic [NUM_IN-1:0] raw;
  logic [NUM_IN-1:0] db;
  logic [15:0]       sw_db;
  logic [4:0]        btn_db;
  logic [4:0]        btn_prev;
  logic [4:0]        rise;
  logic [4:0]        press;
  logic [15:0]       press_cnt;
  logic              rd_en;
  logic              rd_clr;
  logic [31:0]       rdata;

  assign sample = (tick == TICK_MAX);

  always_ff @(posedge clk) begin
    if (reset)
      tick <= '0;
    else if (sample)
      tick <= '0;
    else
      tick <= tick + 1'b1;
  end

  assign raw = {btn, sw};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_db
    debounce_bit #(
      .DEB_SAMPLES (DEB_SAMPLES)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .sample (sample),
      .din    (raw[i]),
      .dout   (db[i])
    );
  end

  assign sw_db  = db[NUM_SW-1:0];
  assign btn_db = db[NUM_IN-1:NUM_SW];

  // btn_prev resets to 0, so a button held through reset
  // counts as a press once it is accepted.
  assign rise   = btn_db & ~btn_prev;
  assign rd_en  = bus.cs & bus.rd;
  assign rd_clr = rd_en & (bus.addr == REG_PRESS);

  // Clear and set share an edge: a new rise survives the clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_prev  <= '0;
      press     <= '0;
      press_cnt <= '0;
    end else begin
      btn_prev  <= btn_db;
      press     <= (rd_clr ? 5'b0 : press) | rise;
      press_cnt <= press_cnt + {13'b0, count_ones5(rise)};
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      unique case (1'b1)
        bus.addr == REG_SW:    rdata = {16'b0, sw_db};
        bus.addr == REG_BTN:   rdata = {27'b0, btn_db};
        bus.addr == REG_PRESS: rdata = {27'b0, press};
        bus.addr == REG_CNT:   rdata = {16'b0, press_cnt};
        default:               rdata = '0;
      endcase
    end
  end

  assign bus.rdata = rdata;

endmodule

// File: tb/tb_sw_btn_reader.sv
// Bench for sw_btn_reader: streak-based reference model plus
// directed scenarios with literal expectations.
module tb_sw_btn_reader;
  import sw_btn_reader_pkg::*;

  localparam int T = 4;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] sw, sw2;
  logic [4:0]  btn, btn2;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  sw_btn_reader_if bus ();
  sw_btn_reader_if bus2 ();

  always #5 clk = ~clk;

  sw_btn_reader #(
    .DEB_TICK    (T),
    .DEB_SAMPLES (N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .sw    (sw),
    .btn   (btn)
  );

  sw_btn_reader #(
    .DEB_TICK    (1),
    .DEB_SAMPLES (2)
  ) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2),
    .sw    (sw2),
    .btn   (btn2)
  );

  // Reference model: raw input seen two cycles late, a sample
  // every T cycles since reset, and a bit accepted once its
  // run of equal samples reaches N (reset counts as N zeros).
  logic [20:0] m_s1 = '0, m_s2 = '0;
  logic [20:0] m_db = '0, m_last = '0;
  int          m_run [21];
  int          m_cyc = 0;
  logic [4:0]  m_prev = '0, m_press = '0;
  int          m_cnt = 0;

  always @(posedge clk) begin
    logic [4:0] up;
    logic       v;
    if (reset) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_last = '0;
      for (int b = 0; b < 21; b++) m_run[b] = N;
      m_cyc = 0; m_prev = '0; m_press = '0; m_cnt = 0;
    end else begin
      up = m_db[20:16] & ~m_prev;
      if (bus.cs && bus.rd && bus.addr == 2'd2)
        m_press = '0;
      m_press = m_press | up;
      m_cnt = (m_cnt + $countones(up)) % 65536;
      m_prev = m_db[20:16];
      if (m_cyc % T == T - 1) begin
        for (int b = 0; b < 21; b++) begin
          v = m_s2[b];
          if (v == m_last[b]) begin
            if (m_run[b] < N) m_run[b]++;
          end else begin
            m_run[b] = 1;
            m_last[b] = v;
          end
          if (m_run[b] >= N) m_db[b] = v;
        end
      end
      m_s2 = m_s1;
      m_s1 = {btn, sw};
      m_cyc++;
    end
  end

  function automatic logic [31:0] model_rdata();
    if (!(bus.cs && bus.rd)) return 32'h0;
    case (bus.addr)
      2'd0:    return {16'h0, m_db[15:0]};
      2'd1:    return {27'h0, m_db[20:16]};
      2'd2:    return {27'h0, m_press};
      default: return 32'(m_cnt);
    endcase
  endfunction

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  always @(negedge clk)
    if (chk_en) check("cycle", bus.rdata, model_rdata());

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd_chk(input string name,
                        input logic [1:0] a,
                        input logic [31:0] exp);
    bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = a;
    @(negedge clk);
    check(name, bus.rdata, exp);
    step(1);
    bus.cs = 1'b0; bus.rd = 1'b0;
  endtask

  initial begin
    int   rises, nz, n8;
    logic prev_b;
    reset = 1'b1;
    sw = '0; btn = '0; sw2 = '0; btn2 = '0;
    bus.cs = 0; bus.rd = 0; bus.addr = 0;
    bus2.cs = 0; bus2.rd = 0; bus2.addr = 0;
    step(1);
    chk_en = 1'b1;
    rd_chk("rst_sw", REG_SW, 32'h0);
    rd_chk("rst_cnt", REG_CNT, 32'h0);
    reset = 1'b0;
    step(5);

    // stable switch change, worst-case latency 14
    sw = 16'hA5A5;
    bus.cs = 1; bus.rd = 1; bus.addr = REG_SW;
    for (int i = 0; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1)  check("sw_early", bus.rdata, 32'h0);
      if (i == 14) check("sw_lat14", bus.rdata, 32'h0000A5A5);
    end
    step(1);

    // bouncing button 0, then held
    bus.addr = REG_BTN;
    rises = 0; prev_b = 1'b0;
    for (int c = 0; c < 62; c++) begin
      if (c < 42 && c % 3 == 0) btn[0] = ~btn[0];
      else if (c == 42) btn[0] = 1'b1;
      @(negedge clk);
      if (bus.rdata[0] && !prev_b) rises++;
      prev_b = bus.rdata[0];
      step(1);
    end
    bus.cs = 0; bus.rd = 0;
    check("bounce_rises", 32'(rises), 32'd1);
    rd_chk("b_cnt", REG_CNT, 32'd1);
    rd_chk("b_btn", REG_BTN, 32'd1);
    rd_chk("b_press", REG_PRESS, 32'd1);

    // press 0 and 2, clear-on-read
    btn = 5'b00000;
    step(20);
    btn = 5'b00101;
    step(20);
    rd_chk("c_press5", REG_PRESS, 32'h5);
    rd_chk("c_clr", REG_PRESS, 32'h0);
    rd_chk("c_cnt", REG_CNT, 32'd3);

    // button 3 rising under a held clear-read
    btn = 5'b01101;
    bus.cs = 1; bus.rd = 1; bus.addr = REG_PRESS;
    nz = 0; n8 = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.rdata != 0) nz++;
      if (bus.rdata == 32'h8) n8++;
      step(1);
    end
    bus.cs = 0; bus.rd = 0;
    check("d_nonzero", 32'(nz), 32'd1);
    check("d_val8", 32'(n8), 32'd1);
    rd_chk("d_cnt", REG_CNT, 32'd4);

    // one-cycle reset mid-count with inputs held
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    rd_chk("e_sw0", REG_SW, 32'h0);
    rd_chk("e_btn0", REG_BTN, 32'h0);
    rd_chk("e_press0", REG_PRESS, 32'h0);
    rd_chk("e_cnt0", REG_CNT, 32'h0);
    step(9);
    rd_chk("e_sw_back", REG_SW, 32'h0000A5A5);
    rd_chk("e_cnt3", REG_CNT, 32'd3);
    rd_chk("e_press_d", REG_PRESS, 32'hD);
    bus.cs = 0; bus.rd = 1; bus.addr = REG_CNT;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("e_cs0", bus.rdata, 32'h0);
      step(1);
    end
    bus.cs = 1; bus.rd = 0;
    @(negedge clk);
    check("e_rd0", bus.rdata, 32'h0);
    step(1);
    bus.cs = 0;

    // counter wrap on the fast instance: 13107 rounds of +5
    bus2.cs = 1; bus2.rd = 1; bus2.addr = REG_CNT;
    for (int r = 0; r < 13107; r++) begin
      btn2 = 5'h1F;
      step(2);
      btn2 = 5'h00;
      step(2);
    end
    step(6);
    @(negedge clk);
    check("f_cnt_ffff", bus2.rdata, 32'h0000FFFF);
    step(1);
    btn2 = 5'h01;
    step(4);
    btn2 = 5'h00;
    step(6);
    @(negedge clk);
    check("f_cnt_wrap", bus2.rdata, 32'h0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
